// File: rtl/joy_serial_multi_if.sv
// Pin-level bundle between the user-port chain reader and its surroundings.
// The reader takes the slave side; whatever drives enable and the chain
// data (the emu top, or a bench) takes the master side.
interface joy_serial_multi_if #(
   parameter int N = 24
);
   logic          enable;
   logic          joy_clk;
   logic          joy_load;
   logic          joy_data;
   logic [N-1:0]  joystick;
   logic          frame_strobe;
   logic          changed;

   modport master (
      output enable,
      output joy_data,
      input  joy_clk,
      input  joy_load,
      input  joystick,
      input  frame_strobe,
      input  changed
   );

   modport slave (
      input  enable,
      input  joy_data,
      output joy_clk,
      output joy_load,
      output joystick,
      output frame_strobe,
      output changed
   );
endinterface

// File: rtl/joy_serial_multi.sv
// Reader for a daisy chain of 74HC165-style PISO adapters on the user port.
// Each frame: idle gap, active-low parallel load, then N bits shifted out
// (bit 0 is QH straight after the load, so it is sampled before the first
// rising joy_clk). A frame is only committed to joystick after DEBOUNCE
// identical consecutive frames. joy_clk and joy_load never move together.
module joy_serial_multi #(
   parameter int PLAYERS    = 2,
   parameter int BITS       = 12,
   parameter int CLK_DIV    = 16,
   parameter int POLL_GAP   = 256,
   parameter int ACTIVE_LOW = 1,
   parameter int DEBOUNCE   = 2
) (
   input logic               clk,
   input logic               reset,
   joy_serial_multi_if.slave bus
);
   localparam int N     = PLAYERS * BITS;
   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
   localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
   localparam logic             POL      = (ACTIVE_LOW != 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state_reg;
   logic [GAP_W-1:0] gap_reg;
   logic [DIV_W-1:0] div_reg;
   logic [BIT_W-1:0] bit_idx_reg;
   logic             phase_reg;      // 0: joy_clk low phase, 1: high phase
   logic             joy_clk_reg;
   logic             joy_load_reg;
   logic             strobe_reg;
   logic             changed_reg;
   logic [N-1:0]     sreg_reg;
   logic [N-1:0]     sreg_next;
   logic [N-1:0]     cand_reg;
   logic [N-1:0]     cand_next;
   logic [N-1:0]     joystick_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             commit;
   logic             sample_en;
   logic             data_bit;

   assign bus.joy_clk      = joy_clk_reg;
   assign bus.joy_load     = joy_load_reg;
   assign bus.joystick     = joystick_reg;
   assign bus.frame_strobe = strobe_reg;
   assign bus.changed      = changed_reg;

   // The chain bit is taken on the last cycle of the low phase of its slot.
   assign sample_en = bus.enable && (state_reg == ST_SHIFT) && !phase_reg
                      && (div_reg == DIV_LAST);
   assign data_bit  = bus.joy_data ^ POL;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_sreg
         assign sreg_next[gi] = (sample_en && (bit_idx_reg == BIT_W'(gi)))
                                ? data_bit : sreg_reg[gi];
      end
   endgenerate

   // Debounce outcome for the frame just completed in sreg_reg.
   always_comb begin
      cand_next = cand_reg;
      cnt_next  = cnt_reg;
      if (sreg_reg == cand_reg) begin
         if (cnt_reg != DEB_MAX)
            cnt_next = cnt_reg + 1'b1;
      end else begin
         cand_next = sreg_reg;
         cnt_next  = CNT_W'(1);
      end
      commit = (cnt_next == DEB_MAX) && (cand_next != joystick_reg);
   end

   // Shift register capture; a partial frame never reaches the debouncer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sreg_reg <= '0;
      else
         sreg_reg <= sreg_next;
   end

   // Frame sequencer, pin drivers and debounce commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         gap_reg      <= '0;
         div_reg      <= '0;
         bit_idx_reg  <= '0;
         phase_reg    <= 1'b0;
         joy_clk_reg  <= 1'b0;
         joy_load_reg <= 1'b1;
         strobe_reg   <= 1'b0;
         changed_reg  <= 1'b0;
         cand_reg     <= '0;
         cnt_reg      <= '0;
         joystick_reg <= '0;
      end else if (!bus.enable) begin
         // abort: idle pins, fresh gap, and the match history is forgotten
         state_reg    <= ST_IDLE;
         gap_reg      <= '0;
         div_reg      <= '0;
         bit_idx_reg  <= '0;
         phase_reg    <= 1'b0;
         joy_clk_reg  <= 1'b0;
         joy_load_reg <= 1'b1;
         strobe_reg   <= 1'b0;
         changed_reg  <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         strobe_reg  <= 1'b0;
         changed_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (gap_reg == GAP_LAST) begin
                  gap_reg      <= '0;
                  div_reg      <= '0;
                  joy_load_reg <= 1'b0;
                  state_reg    <= ST_LOAD;
               end else begin
                  gap_reg <= gap_reg + 1'b1;
               end
            end
            ST_LOAD: begin
               if (div_reg == DIV_LAST) begin
                  div_reg      <= '0;
                  bit_idx_reg  <= '0;
                  phase_reg    <= 1'b0;
                  joy_load_reg <= 1'b1;
                  state_reg    <= ST_SHIFT;
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (div_reg == DIV_LAST) begin
                  div_reg <= '0;
                  if (!phase_reg) begin
                     phase_reg   <= 1'b1;
                     joy_clk_reg <= 1'b1;
                  end else begin
                     phase_reg   <= 1'b0;
                     joy_clk_reg <= 1'b0;
                     if (bit_idx_reg == BIT_LAST) begin
                        // results become visible during the single DONE cycle
                        state_reg  <= ST_DONE;
                        strobe_reg <= 1'b1;
                        cand_reg   <= cand_next;
                        cnt_reg    <= cnt_next;
                        if (commit) begin
                           joystick_reg <= cand_next;
                           changed_reg  <= 1'b1;
                        end
                     end else begin
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                     end
                  end
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_joy_serial_multi.sv
// Bench for joy_serial_multi: a behavioural 165 chain feeds the reader and a
// scoreboard of per-frame expectations is checked on every frame_strobe.
module tb_joy_serial_multi;
   localparam int N = 24;

   typedef struct packed {
      logic [N-1:0] joy;
      logic         chg;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] image = '0;
   logic [N-1:0] chain = '1;
   logic         stuck_en = 1'b0;
   logic         stuck_val = 1'b0;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   // monitor state
   int   cyc = 0;
   int   strobe_cnt = 0;
   int   changed_cnt = 0;
   int   rises = 0;
   int   last_rise = 0;
   int   hi_len = 0;
   int   hi_min = 999;
   int   hi_max = 0;
   int   per_min = 999;
   int   per_max = 0;
   int   load_len = 0;
   int   last_strobe = 0;
   bit   period_valid = 1'b0;
   logic prev_clk = 1'b0;
   logic prev_load = 1'b1;

   logic [N-1:0] deb_img [5] = '{24'h000001, 24'h000002, 24'h000001, 24'h000002, 24'h000002};
   logic [N-1:0] deb_joy [5] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h000002};
   logic         deb_chg [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   joy_serial_multi_if #(.N(N)) bus ();

   joy_serial_multi #(
      .PLAYERS(2), .BITS(12), .CLK_DIV(4), .POLL_GAP(8), .ACTIVE_LOW(1), .DEBOUNCE(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // 74HC165 chain: parallel load while low, shift toward QH on rising clock
   always @(negedge bus.joy_load or posedge bus.joy_clk) begin
      if (!bus.joy_load)
         chain <= ~image;
      else
         chain <= {1'b1, chain[N-1:1]};
   end

   assign bus.joy_data = stuck_en ? stuck_val : chain[0];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [N-1:0] joy, input logic chg);
      exp_t e;
      e.joy = joy;
      e.chg = chg;
      sb_q.push_back(e);
   endtask

   task automatic wait_strobe();
      int target;
      int n;
      target = strobe_cnt + 1;
      n = 0;
      while (strobe_cnt < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (strobe_cnt < target)
         check_val("strobe_timeout", 32'd0, 32'd1);
   endtask

   // Measures the start of a frame from a negedge where enable/reset just changed.
   task automatic check_frame_start(input string tag);
      int n;
      n = 0;
      while (bus.joy_load && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_load_fall"}, n, 8);
   endtask

   // Per-cycle pin monitor and scoreboard consumer.
   always @(negedge clk) begin
      cyc++;
      if (reset || !bus.enable) begin
         period_valid = 1'b0;
         rises = 0;
         hi_len = 0;
         hi_min = 999;
         hi_max = 0;
         per_min = 999;
         per_max = 0;
         load_len = 0;
      end else begin
         if ((bus.joy_clk != prev_clk) && (bus.joy_load != prev_load))
            check_val("pin_glitch", 32'd1, 32'd0);
         if (!bus.joy_load)
            load_len++;
         if (bus.joy_clk)
            hi_len++;
         if (bus.joy_clk && !prev_clk) begin
            if (rises > 0) begin
               if (cyc - last_rise < per_min) per_min = cyc - last_rise;
               if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            last_rise = cyc;
            rises++;
         end
         if (!bus.joy_clk && prev_clk) begin
            if (hi_len < hi_min) hi_min = hi_len;
            if (hi_len > hi_max) hi_max = hi_len;
            hi_len = 0;
         end
         if (bus.changed && !bus.frame_strobe)
            check_val("changed_without_strobe", 32'd1, 32'd0);
         if (bus.changed)
            changed_cnt++;
         if (bus.frame_strobe) begin
            if (sb_q.size() == 0) begin
               check_val("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_val("joystick", bus.joystick, e.joy);
               check_val("changed", bus.changed, e.chg);
            end
            check_val("clk_rises", rises, 24);
            check_val("clk_high_min", hi_min, 4);
            check_val("clk_high_max", hi_max, 4);
            check_val("clk_period_min", per_min, 8);
            check_val("clk_period_max", per_max, 8);
            check_val("load_low_len", load_len, 4);
            if (period_valid)
               check_val("strobe_period", cyc - last_strobe, 205);
            period_valid = 1'b1;
            last_strobe = cyc;
            strobe_cnt++;
            rises = 0;
            hi_min = 999;
            hi_max = 0;
            per_min = 999;
            per_max = 0;
            load_len = 0;
         end
      end
      prev_clk = bus.joy_clk;
      prev_load = bus.joy_load;
   end

   initial begin
      int n;
      int saved;
      bus.enable = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_joy_clk", bus.joy_clk, 32'd0);
      check_val("rst_joy_load", bus.joy_load, 32'd1);
      check_val("rst_joystick", bus.joystick, 32'd0);
      check_val("rst_strobe", bus.frame_strobe, 32'd0);
      check_val("rst_changed", bus.changed, 32'd0);

      // decode: active-low image of 00AC35 through the chain
      image = 24'h00AC35;
      push_exp(24'h0, 1'b0);
      push_exp(24'h00AC35, 1'b1);
      push_exp(24'h00AC35, 1'b0);
      reset = 1'b0;
      bus.enable = 1'b1;
      check_frame_start("first");
      repeat (3) wait_strobe();
      check_val("decode_changed_count", changed_cnt, 1);

      // abort during the high phase of bit 10
      image = 24'h123456;
      n = 0;
      while (!(rises == 11 && bus.joy_clk) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_val("abort_reach_bit10", n < 400, 32'd1);
      saved = strobe_cnt;
      bus.enable = 1'b0;
      @(negedge clk);
      check_val("abort_joy_clk", bus.joy_clk, 32'd0);
      check_val("abort_joy_load", bus.joy_load, 32'd1);
      check_val("abort_joystick", bus.joystick, 32'h00AC35);
      repeat (300) @(negedge clk);
      check_val("abort_no_strobe", strobe_cnt, saved);
      check_val("abort_hold_joystick", bus.joystick, 32'h00AC35);

      // re-enable: fresh frame, two matching frames needed again
      push_exp(24'h00AC35, 1'b0);
      push_exp(24'h123456, 1'b1);
      bus.enable = 1'b1;
      check_frame_start("reenable");
      n = 0;
      while (!bus.frame_strobe && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_val("reenable_load_to_strobe", n, 196);
      @(negedge clk);
      wait_strobe();

      // reset while joy_clk is high
      image = 24'h0F0F0F;
      n = 0;
      while (!bus.joy_clk && n < 400) begin
         @(negedge clk);
         n++;
      end
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_joy_clk", bus.joy_clk, 32'd0);
      check_val("arst_joy_load", bus.joy_load, 32'd1);
      check_val("arst_joystick", bus.joystick, 32'd0);
      check_val("arst_strobe", bus.frame_strobe, 32'd0);
      sb_q.delete();
      repeat (3) @(negedge clk);

      // debounce: alternating frames never commit, a held value does
      image = deb_img[0];
      for (int i = 0; i < 5; i++)
         push_exp(deb_joy[i], deb_chg[i]);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         image = deb_img[i];
         wait_strobe();
      end

      // polarity: stuck high reads as released, stuck low as all pressed
      @(negedge clk);
      reset = 1'b1;
      stuck_en = 1'b1;
      stuck_val = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++)
         push_exp(24'h0, 1'b0);
      reset = 1'b0;
      repeat (3) wait_strobe();
      stuck_val = 1'b0;
      push_exp(24'h0, 1'b0);
      push_exp(24'hFFFFFF, 1'b1);
      repeat (2) wait_strobe();

      check_val("scoreboard_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
